reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_if.sv | 22 ++
 rtl/reg_dump_reader.sv | 131 +++++++++++++
 tb/tb_reg_dump_reader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_if.sv
// reg_dump_if: control, register-file read port and output stream of the register dump reader.
// master: the dump reader (drives rf_src, out_*, busy, done); slave: its environment.
interface reg_dump_if;
  logic        start;
  logic [3:0]  rf_src;
  logic [63:0] rf_val;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;
  modport master (
    input  start, rf_val, out_ready,
    output rf_src, out_valid, out_data, out_idx, out_last, busy, done
  );
  modport slave (
    output start, rf_val, out_ready,
    input  rf_src, out_valid, out_data, out_idx, out_last, busy, done
  );
endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: reads registers FIRST_REG..LAST_REG one per READ cycle and streams them out under valid/ready.
// Ports: clk; rst (asynchronous, active-high); bus (reg_dump_if.master) carrying start/busy/done,
// the register-file read port rf_src/rf_val and the output stream out_valid/out_ready/out_data/out_idx/out_last.
// Option: define REG_DUMP_CHECKSUM_EN to append an XOR checksum word (out_idx 4'hF, out_last 1) after the registers.
module reg_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 14
) (
  input logic        clk,
  input logic        rst,
  reg_dump_if.master bus
);
  localparam logic [3:0] FIRST = 4'(FIRST_REG);
  localparam logic [3:0] LAST  = 4'(LAST_REG);
  localparam logic [3:0] RNONE = 4'hF;
`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, SEND, DONE} state_t;
`endif
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  rf_src_q, rf_src_d;
  logic [3:0]  out_idx_q, out_idx_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [63:0] csum_q, csum_d;
`endif
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = READ;
        idx_d   = FIRST;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d  = '0;
`endif
      end
      READ: begin
        state_d    = SEND;
        out_data_d = bus.rf_val;
        out_idx_d  = idx_q;
`ifdef REG_DUMP_CHECKSUM_EN
        out_last_d = 1'b0;
`else
        out_last_d = idx_q == LAST;
`endif
      end
      SEND: if (bus.out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d = csum_q ^ out_data_q;
`endif
        if (idx_q != LAST) begin
          idx_d   = idx_q + 4'd1;
          state_d = READ;
        end else begin
`ifdef REG_DUMP_CHECKSUM_EN
          // checksum word includes the register word accepted at this same edge
          state_d    = CSUM;
          out_data_d = csum_q ^ out_data_q;
          out_idx_d  = RNONE;
          out_last_d = 1'b1;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: if (bus.out_ready) state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with the state they describe
    rf_src_d    = (state_d == READ) ? idx_d : RNONE;
`ifdef REG_DUMP_CHECKSUM_EN
    out_valid_d = (state_d == SEND) || (state_d == CSUM);
`else
    out_valid_d = state_d == SEND;
`endif
    busy_d      = state_d != IDLE;
    done_d      = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rf_src_q    <= RNONE;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rf_src_q    <= rf_src_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end
  assign bus.rf_src    = rf_src_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: random and directed stimulus checked every cycle against a word-level dump model.
module tb_reg_dump_reader;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  localparam int FIRST = 0;
  localparam int LAST  = 14;
  typedef struct {
    logic [3:0]  idx;
    logic [63:0] data;
    logic        last;
  } word_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] regs [16];
  word_t wlog[$];
  word_t wlog2[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  reg_dump_if bus();
  reg_dump_if bus2();
  assign bus.rf_val  = regs[bus.rf_src];
  assign bus2.rf_val = regs[bus2.rf_src];
  reg_dump_reader dut (.clk(clk), .rst(rst), .bus(bus));
  reg_dump_reader #(.FIRST_REG(3), .LAST_REG(5)) u2 (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;
  // model: what the stream must show after each edge
  logic        m_valid, m_busy, m_done, m_wait, m_last;
  logic [3:0]  m_idx;
  logic [63:0] m_data, m_csum;
  int          m_nxt;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_valid = 0; m_busy = 0; m_done = 0; m_wait = 0; m_last = 0;
    m_idx = 0; m_data = 0; m_csum = 0; m_nxt = 0;
  endtask
  task automatic model_tick();
    if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (bus.start) begin m_busy = 1; m_nxt = FIRST; m_wait = 1; m_csum = 0; end
    end else if (m_wait) begin
      m_wait = 0; m_valid = 1; m_idx = 4'(m_nxt); m_data = regs[m_nxt];
      m_last = (m_nxt == LAST) && !CS;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 0;
      if (m_idx == 4'hF) m_done = 1;
      else begin
        m_csum ^= m_data;
        if (m_nxt == LAST) begin
          if (CS) begin m_valid = 1; m_idx = 4'hF; m_data = m_csum; m_last = 1; end
          else m_done = 1;
        end else begin
          m_nxt++;
          m_wait = 1;
        end
      end
    end
  endtask
  always @(posedge clk) begin
    if (rst) model_reset();
    else begin
      model_tick();
      #1;
      if (!rst) begin
        chk("out_valid", bus.out_valid, m_valid);
        chk("busy", bus.busy, m_busy);
        chk("done", bus.done, m_done);
        chk("rf_src", bus.rf_src, m_wait ? 64'(m_nxt) : 64'hF);
        if (m_valid) begin
          chk("out_idx", bus.out_idx, m_idx);
          chk("out_data", bus.out_data, m_data);
          chk("out_last", bus.out_last, m_last);
        end
      end
    end
  end
  always @(posedge clk) begin
    if (!rst && bus.done) done_cnt++;
    if (!rst && bus.out_valid && bus.out_ready) wlog.push_back('{bus.out_idx, bus.out_data, bus.out_last});
    if (!rst && bus2.out_valid && bus2.out_ready) wlog2.push_back('{bus2.out_idx, bus2.out_data, bus2.out_last});
  end
  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_word(input logic [3:0] i);
    int k = 0;
    while (!(bus.out_valid && bus.out_idx == i) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("wait_word_idx", bus.out_idx, i);
  endtask
  task automatic wait_done(input string name);
    int n0 = done_cnt;
    int k = 0;
    while (done_cnt == n0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(name, 64'(done_cnt != n0), 64'd1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n0, nl;
    model_reset();
    bus.start = 0; bus.out_ready = 0; bus2.start = 0; bus2.out_ready = 1;
    for (int i = 0; i < 16; i++) regs[i] = (i < 15) ? 64'h1000 + 64'(i) : 64'h0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_src", bus.rf_src, 64'hF);
    chk("rst_idx", bus.out_idx, 0);
    chk("rst_data", bus.out_data, 0);
    rst = 0;
    // full dump, consumer always ready
    bus.out_ready = 1;
    wlog.delete();
    do_start();
    chk("lat1_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat2_valid", bus.out_valid, 1);
    chk("first_idx", bus.out_idx, 0);
    chk("first_data", bus.out_data, 64'h1000);
    wait_done("done_full");
    chk("full_count", wlog.size(), 15 + 64'(CS));
    chk("full_d0", wlog[0].data, 64'h1000);
    chk("full_i14", wlog[14].idx, 14);
    chk("full_d14", wlog[14].data, 64'h100E);
    nl = 0;
    foreach (wlog[i]) nl += int'(wlog[i].last);
    chk("last_count", nl, 1);
`ifdef REG_DUMP_CHECKSUM_EN
    chk("csum_idx", wlog[15].idx, 4'hF);
    chk("csum_data", wlog[15].data, 64'h100F);
    chk("csum_last", wlog[15].last, 1);
`else
    chk("last_on_14", wlog[14].last, 1);
`endif
    // backpressure on idx 3
    wlog.delete();
    do_start();
    wait_word(3);
    bus.out_ready = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_idx", bus.out_idx, 3);
      chk("hold_data", bus.out_data, 64'h1003);
    end
    bus.out_ready = 1;
    wait_done("done_hold");
    chk("hold_count", wlog.size(), 15 + 64'(CS));
    chk("hold_next", wlog[4].idx, 4);
    // start during a dump is ignored
    wlog.delete();
    n0 = done_cnt;
    do_start();
    wait_word(6);
    bus.start = 1;
    @(posedge clk);
    #1 bus.start = 0;
    wait_done("done_restart");
    repeat (40) @(posedge clk);
    chk("single_done", done_cnt - n0, 1);
    chk("restart_count", wlog.size(), 15 + 64'(CS));
    // asynchronous reset mid-dump
    do_start();
    wait_word(7);
    #2 rst = 1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_src", bus.rf_src, 64'hF);
    chk("arst_done", bus.done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    do_start();
    @(posedge clk);
    #1;
    chk("arst_first_valid", bus.out_valid, 1);
    chk("arst_first_idx", bus.out_idx, 0);
    wait_done("done_after_rst");
    // random traffic, register writes and occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bus.out_ready = ($urandom % 3) != 0;
      bus.start = ($urandom % 8) == 0;
      if ($urandom % 4 == 0) regs[$urandom % 15] = {$urandom, $urandom};
      if (rst) rst = 0;
      else if ($urandom % 400 == 0) rst = 1;
    end
    @(negedge clk);
    rst = 0; bus.start = 0; bus.out_ready = 1;
    repeat (60) @(negedge clk);
    // narrow window instance
    wlog2.delete();
    bus2.start = 1;
    @(negedge clk);
    bus2.start = 0;
    repeat (20) @(negedge clk);
    chk("win_count", wlog2.size(), 3 + 64'(CS));
    for (int k = 0; k < 3; k++) begin
      chk("win_idx", wlog2[k].idx, 3 + k);
      chk("win_data", wlog2[k].data, regs[3 + k]);
      chk("win_last", wlog2[k].last, (k == 2) && !CS);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
